// File: rtl/poly_pkg.sv
// Shared types for the quadratic evaluator: FSM states, default widths,
// and the accumulator source-select encodings used between control and datapath.
package poly_pkg;

  localparam int W_DEF  = 16;
  localparam int XW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL1,
    ADD1,
    MUL2,
    ADD2,
    DONE
  } state_t;

  // Source of the next accumulator value
  localparam logic [2:0] SEL_ACC = 3'd0;
  localparam logic [2:0] SEL_X   = 3'd1;
  localparam logic [2:0] SEL_B   = 3'd2;
  localparam logic [2:0] SEL_C   = 3'd3;
  localparam logic [2:0] SEL_A   = 3'd4;

endpackage

// File: rtl/poly_ctrl.sv
// Sequencer for Horner evaluation: one state per clock, all outputs registered.
// finished rises 6 edges after Start is sampled; Start is only looked at in IDLE and DONE.
module poly_ctrl
  import poly_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic       start,
  output logic       ld_x,
  output logic       ld_s,
  output logic       ovf_clr,
  output logic       res_ld,
  output logic       finished,
  output logic [2:0] s_sel
);

  state_t state;

  // Outputs are decoded from the state being entered, so they line up with it
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      ld_x     <= 1'b0;
      ld_s     <= 1'b0;
      ovf_clr  <= 1'b0;
      res_ld   <= 1'b0;
      finished <= 1'b0;
      s_sel    <= SEL_ACC;
    end else begin
      ld_x     <= 1'b0;
      ld_s     <= 1'b0;
      ovf_clr  <= 1'b0;
      res_ld   <= 1'b0;
      finished <= 1'b0;
      s_sel    <= SEL_ACC;
      case (state)
        IDLE: if (start) begin
          state   <= LOAD;
          ld_x    <= 1'b1;
          ld_s    <= 1'b1;
          ovf_clr <= 1'b1;
          s_sel   <= SEL_A;
        end
        LOAD: begin
          state <= MUL1;
          ld_s  <= 1'b1;
          s_sel <= SEL_X;
        end
        MUL1: begin
          state <= ADD1;
          ld_s  <= 1'b1;
          s_sel <= SEL_B;
        end
        ADD1: begin
          state <= MUL2;
          ld_s  <= 1'b1;
          s_sel <= SEL_X;
        end
        MUL2: begin
          state  <= ADD2;
          ld_s   <= 1'b1;
          s_sel  <= SEL_C;
          res_ld <= 1'b1;
        end
        ADD2: state <= DONE;
        DONE: begin
          finished <= 1'b1;
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/poly_eval_unit.sv
// Evaluates A*X^2 + B*X + C by Horner's rule on one accumulator, with sticky signed overflow.
// Latency: finished rises 6 edges after Start is sampled; holds while Start stays high.
module poly_eval_unit
  import poly_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int XW = XW_DEF
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [XW-1:0] X,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [W-1:0]  C,
  output logic [W-1:0]  Resultado,
  output logic          Overflow,
  output logic          finished
);

  logic         ld_x, ld_s, ovf_clr, res_ld;
  logic [2:0]   s_sel;
  logic [W-1:0] s, xs, b_q, c_q;
  logic [W-1:0] addend, sum, s_nxt;
  logic [2*W-1:0] prod;
  logic         mul_ovf, add_ovf, step_ovf;

  poly_ctrl u_ctrl (
    .clk      (clk),
    .arst_n   (Reset),
    .start    (Start),
    .ld_x     (ld_x),
    .ld_s     (ld_s),
    .ovf_clr  (ovf_clr),
    .res_ld   (res_ld),
    .finished (finished),
    .s_sel    (s_sel)
  );

  // Both operands sign-extended to 2W, so the low 2W bits are the exact signed product
  assign prod    = {{W{s[W-1]}}, s} * {{W{xs[W-1]}}, xs};
  assign mul_ovf = (prod[2*W-1:W-1] != {(W+1){prod[W-1]}});

  assign addend  = (s_sel == SEL_C) ? c_q : b_q;
  assign sum     = s + addend;
  assign add_ovf = (s[W-1] == addend[W-1]) && (sum[W-1] != s[W-1]);

  always_comb begin
    s_nxt    = s;
    step_ovf = 1'b0;
    case (s_sel)
      SEL_A: s_nxt = A;
      SEL_X: begin
        s_nxt    = prod[W-1:0];
        step_ovf = mul_ovf;
      end
      SEL_B, SEL_C: begin
        s_nxt    = sum;
        step_ovf = add_ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      s         <= '0;
      xs        <= '0;
      b_q       <= '0;
      c_q       <= '0;
      Resultado <= '0;
      Overflow  <= 1'b0;
    end else begin
      if (ld_x) begin
        xs  <= {{(W-XW){X[XW-1]}}, X};
        b_q <= B;
        c_q <= C;
      end
      if (ld_s) s <= s_nxt;
      if (ovf_clr)
        Overflow <= 1'b0;
      else if (ld_s && step_ovf)
        Overflow <= 1'b1;
      // Final add result is captured on the same edge that enters DONE
      if (res_ld) Resultado <= sum;
    end
  end

endmodule

// File: tb/tb_poly_eval_unit.sv
// Random and directed checks of poly_eval_unit against an integer reference model.
module tb_poly_eval_unit;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  X;
  logic [15:0] A, B, C;
  logic [15:0] Resultado;
  logic        Overflow;
  logic        finished;

  int n_chk  = 0;
  int n_fail = 0;

  poly_eval_unit dut (
    .clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .X         (X),
    .A         (A),
    .B         (B),
    .C         (C),
    .Resultado (Resultado),
    .Overflow  (Overflow),
    .finished  (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return longint'($signed(t));
  endfunction

  function automatic bit out_of_range(input longint v);
    return (v < -32768) || (v > 32767);
  endfunction

  // Reference: Horner steps in wide integers, each step checked then wrapped to 16 bits
  task automatic model(input int x, input int a, input int b, input int c,
                       output longint res, output bit ovf);
    longint s;
    ovf = 1'b0;
    s = a;
    s = s * x;  ovf |= out_of_range(s); s = wrap16(s);
    s = s + b;  ovf |= out_of_range(s); s = wrap16(s);
    s = s * x;  ovf |= out_of_range(s); s = wrap16(s);
    s = s + c;  ovf |= out_of_range(s); s = wrap16(s);
    res = s;
  endtask

  function automatic int rnd_w();
    logic [15:0] t;
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 40)) - 20;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  function automatic int rnd_x();
    logic [7:0] t;
    t = 8'($urandom);
    return int'($signed(t));
  endfunction

  // One full computation: latency, result, hold while Start=1, release and hold in IDLE
  task automatic run(input int x, input int a, input int b, input int c, input bit jitter,
                     output longint res_o, output bit ovf_o);
    longint exp_res;
    bit     exp_ovf;
    int     seen;
    logic [31:0] xv, av, bv, cv;
    model(x, a, b, c, exp_res, exp_ovf);
    xv = x; av = a; bv = b; cv = c;
    @(negedge clk);
    X = xv[7:0]; A = av[15:0]; B = bv[15:0]; C = cv[15:0];
    Start = 1'b1;
    seen = 0;
    for (int k = 1; k <= 12 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (finished) seen = k;
      else if (k > 2 && jitter) begin
        // Operands are already latched; scramble them and toggle Start mid-computation
        X = 8'($urandom); A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
        Start = (k <= 5) ? 1'($urandom) : 1'b1;
      end
    end
    chk("latency", seen, 7);
    res_o = longint'($signed(Resultado));
    ovf_o = Overflow;
    chk("result", res_o, exp_res);
    chk("overflow", ovf_o, exp_ovf);
    repeat (2) @(posedge clk);
    #1 chk("finished_hold", finished, 1);
    @(negedge clk);
    Start = 1'b0;
    for (int k = 0; k < 4 && finished; k++) begin
      @(posedge clk); #1;
    end
    chk("finished_drop", finished, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_result_hold", longint'($signed(Resultado)), exp_res);
    chk("idle_ovf_hold", Overflow, exp_ovf);
  endtask

  longint r;
  bit     o;

  initial begin
    Reset = 1'b0; Start = 1'b0; X = '0; A = '0; B = '0; C = '0;
    #12;
    chk("rst_finished", finished, 0);
    chk("rst_result", Resultado, 0);
    chk("rst_ovf", Overflow, 0);
    @(negedge clk) Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_finished", finished, 0);
    end
    chk("idle_result", Resultado, 0);
    chk("idle_ovf", Overflow, 0);

    run(-20, 3, 4, 5, 1'b0, r, o);
    chk("tp1_value", r, 1125);
    chk("tp1_ovf", o, 0);

    @(negedge clk) Reset = 1'b0;
    @(negedge clk) Reset = 1'b1;
    run(6, 4, 5, 32767, 1'b0, r, o);
    chk("tp2_value", r, -32595);
    chk("tp2_ovf", o, 1);

    run(0, 32767, 32767, -7, 1'b0, r, o);
    chk("tp3_value", r, -7);
    chk("tp3_ovf", o, 0);

    run(127, 256, 0, 0, 1'b0, r, o);
    chk("tp4_ovf", o, 1);

    // Abort while the second multiply is in flight
    @(negedge clk);
    X = 8'd3; A = 16'd2; B = 16'd1; C = 16'd1; Start = 1'b1;
    repeat (4) @(posedge clk);
    #1 Reset = 1'b0;
    #1;
    chk("abort_finished", finished, 0);
    chk("abort_result", Resultado, 0);
    chk("abort_ovf", Overflow, 0);
    Start = 1'b0;
    @(negedge clk) Reset = 1'b1;
    run(-1, 1, 1, 1, 1'b0, r, o);
    chk("tp5_value", r, 1);
    chk("tp5_ovf", o, 0);

    for (int i = 0; i < 40; i++)
      run(rnd_x(), rnd_w(), rnd_w(), rnd_w(), (i % 2) == 1, r, o);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
